// File: rtl/mul_add8_seq.sv
// mul_add8_seq: sequential 8x8 shift-and-add multiplier computing P = A*B + C over 8 fixed iterations
module mul_add8_seq (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [7:0]  A,
    input  logic [7:0]  B,
    input  logic [7:0]  C,
    output logic [15:0] P,
    output logic        busy,
    output logic        done
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t      state;
    logic [15:0] acc;
    logic [15:0] mcand;
    logic [15:0] acc_next;
    logic [7:0]  mplier;
    logic [2:0]  cnt;
    assign acc_next = mplier[0] ? acc + mcand : acc;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
            P      <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    acc    <= {8'h00, C};
                    mcand  <= {8'h00, A};
                    mplier <= B;
                    cnt    <= '0;
                    busy   <= 1'b1;
                    state  <= RUN;
                end
                RUN: begin
                    acc    <= acc_next;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 3'd1;
                    if (cnt == 3'd7) begin
                        P     <= acc_next;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mul_add8_seq.sv
// tb_mul_add8_seq: table vectors, random ops and divider round trips against an arithmetic model
module tb_mul_add8_seq;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  A = '0;
    logic [7:0]  B = '0;
    logic [7:0]  C = '0;
    logic [15:0] P;
    logic        busy;
    logic        done;
    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [7:0]  c;
        logic [15:0] p;
        bit          glitch;
    } vec_t;
    vec_t tbl[5];

    mul_add8_seq dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .A(A), .B(B), .C(C),
        .P(P), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // One operation from IDLE; optional stray start pulses at run cycles 3 and 6
    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                          input int exp, input bit glitch);
        int lat, busy_n, extra;
        logic [15:0] prev;
        prev = P;
        @(negedge clk);
        A = a; B = b; C = c; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 0; busy_n = 0;
        while (!done && lat < 20) begin
            if (busy) busy_n++;
            chk("p_hold_during_run", int'(P), int'(prev));
            start = glitch && (lat == 3 || lat == 6);
            if (start) begin A = ~a; B = b + 8'd1; C = c ^ 8'h5A; end
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        if (busy) busy_n++;
        chk("latency", lat, 8);
        chk("result", int'(P), exp);
        chk("busy_cycles", busy_n, 9);
        @(negedge clk);
        chk("done_width", int'(done), 0);
        chk("busy_after", int'(busy), 0);
        chk("p_holds_after", int'(P), exp);
        if (glitch) begin
            extra = 0;
            for (int i = 0; i < 12; i++) begin
                @(negedge clk);
                if (done) extra++;
            end
            chk("stray_done_pulses", extra, 0);
        end
    endtask

    initial begin
        int seen, last_k, dones;
        logic [7:0] ra, rb, rc, dvd, dvs;
        tbl = '{
            '{8'd13,  8'd11,  8'd7,   16'd150,   1'b0},
            '{8'd255, 8'd255, 8'd255, 16'd65280, 1'b0},
            '{8'd0,   8'hA5,  8'd0,   16'd0,     1'b0},
            '{8'd13,  8'd11,  8'd7,   16'd150,   1'b1},
            '{8'd10,  8'd20,  8'd5,   16'd205,   1'b0}
        };
        #1;
        chk("reset_p", int'(P), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 5; i++)
            run_op(tbl[i].a, tbl[i].b, tbl[i].c, int'(tbl[i].p), tbl[i].glitch);

        for (int i = 0; i < 30; i++) begin
            ra = 8'($urandom); rb = 8'($urandom); rc = 8'($urandom);
            run_op(ra, rb, rc, int'(ra) * int'(rb) + int'(rc), 1'b0);
        end

        // Quotient * divisor + remainder must rebuild the dividend
        for (int i = 0; i < 64; i++) begin
            dvd = 8'($urandom);
            dvs = 8'($urandom_range(1, 255));
            run_op(dvd / dvs, dvs, dvd % dvs, int'(dvd), 1'b0);
        end

        // Asynchronous reset in the middle of a run
        @(negedge clk);
        A = 8'd99; B = 8'd77; C = 8'd5; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrun_reset_p", int'(P), 0);
        chk("midrun_reset_busy", int'(busy), 0);
        chk("midrun_reset_done", int'(done), 0);
        @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done || busy) dones++;
        end
        chk("no_activity_after_reset", dones, 0);
        run_op(8'd2, 8'd3, 8'd1, 7, 1'b0);

        // start held high: back-to-back operations every 10 cycles
        @(negedge clk);
        A = 8'd10; B = 8'd20; C = 8'd5; start = 1'b1;
        seen = 0; last_k = -1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (done) begin
                chk("held_start_p", int'(P), 205);
                if (last_k >= 0) chk("held_start_spacing", k - last_k, 10);
                last_k = k;
                seen++;
            end
        end
        start = 1'b0;
        chk("held_start_pulses", seen, 4);
        for (int i = 0; i < 20 && busy; i++) @(negedge clk);
        chk("final_idle", int'(busy), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
